// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_pkg;

    localparam int STATE_W = 2;
    localparam int MAX_W   = 32;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Magnitude of a sign-extended operand; callers keep the low WIDTH bits.
    // The most negative WIDTH-bit value maps to 2^(WIDTH-1), which still fits.
    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] x);
        return x[MAX_W-1] ? ((~x) + MAX_W'(1)) : x;
    endfunction

    // Two's-complement negate at full product width; callers keep 2*WIDTH bits.
    function automatic logic [2*MAX_W-1:0] neg_2w(input logic [2*MAX_W-1:0] x);
        return (~x) + (2*MAX_W)'(1);
    endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Request/result bundle between a requester and the sequential multiplier.
// Latency: none (wires only).
// Backpressure: none; the requester must watch busy/done before issuing start.
interface mult_seq_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] prod_lo;
    logic [WIDTH-1:0] prod_hi;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, prod_lo, prod_hi
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, prod_lo, prod_hi
    );
endinterface

// File: rtl/mult_seq.sv
// Radix-2 shift-add WIDTHxWIDTH multiplier, signed or unsigned, 2*WIDTH-bit result.
// Latency: done rises WIDTH+1 edges after the accepting edge; one product per WIDTH+3 cycles.
// Backpressure: start is only sampled in IDLE; starts while busy or during done are dropped.
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    mult_seq_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             neg_q, neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
    logic [WIDTH-1:0] prod_hi_q, prod_hi_d;

    logic [MAX_W-1:0]   a_ext, b_ext, a_abs, b_abs;
    logic [2*MAX_W-1:0] acc_neg_full;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [PW-1:0]      acc_fixed;
    logic               unused_bits;

    // Operand magnitudes for loading, and the sign-corrected accumulator for FIX.
    always_comb begin
        a_ext        = MAX_W'(signed'(bus.a));
        b_ext        = MAX_W'(signed'(bus.b));
        a_abs        = abs_w(a_ext);
        b_abs        = abs_w(b_ext);
        a_mag        = bus.signed_mode ? a_abs[WIDTH-1:0] : bus.a;
        b_mag        = bus.signed_mode ? b_abs[WIDTH-1:0] : bus.b;
        acc_neg_full = neg_2w((2*MAX_W)'(acc_q));
        acc_fixed    = neg_q ? acc_neg_full[PW-1:0] : acc_q;
        unused_bits  = ^{a_abs, b_abs, acc_neg_full};
    end

    // Next-state and datapath: capture in IDLE, one multiplier bit per CALC cycle,
    // sign fix in FIX, single-cycle done in DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;
        prod_lo_d = prod_lo_q;
        prod_hi_d = prod_hi_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = CALC;
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
                end
            end
            CALC: begin
                // mcand_q already carries the shift for the current bit position.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                acc_d     = acc_fixed;
                prod_lo_d = acc_fixed[WIDTH-1:0];
                prod_hi_d = acc_fixed[PW-1:WIDTH];
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // All state and outputs registered; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            prod_lo_q <= '0;
            prod_hi_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            prod_lo_q <= prod_lo_d;
            prod_hi_q <= prod_hi_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.prod_lo = prod_lo_q;
    assign bus.prod_hi = prod_hi_q;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq at WIDTH=4 and WIDTH=8.
// Latency: n/a.
// Backpressure: n/a.
module tb_mult_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks    = 0;
    int failures  = 0;
    int done_cnt4 = 0;

    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    mult_seq_if #(.WIDTH(4)) if4 ();
    mult_seq_if #(.WIDTH(8)) if8 ();

    mult_seq #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    mult_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    // Counts done pulses of the 4-bit instance.
    always_ff @(posedge clk) begin
        if (if4.done) begin
            done_cnt4 <= done_cnt4 + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Independent reference: sign-extend from bit w-1 when signed, multiply, mask to 2w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] av, input logic [31:0] bv,
                                             input bit sm, input int w);
        longint      sa, sb;
        logic [63:0] p, mask;
        sa = longint'(av);
        sb = longint'(bv);
        if (sm) begin
            if (av[w-1]) sa = sa - (longint'(1) << w);
            if (bv[w-1]) sb = sb - (longint'(1) << w);
        end
        p    = 64'(sa * sb);
        mask = (64'd1 << (2 * w)) - 64'd1;
        return p & mask;
    endfunction

    task automatic drive(input int w, input bit st, input logic [31:0] av,
                         input logic [31:0] bv, input bit sm);
        if (w == 4) begin
            if4.start = st; if4.a = av[3:0]; if4.b = bv[3:0]; if4.signed_mode = sm;
        end else begin
            if8.start = st; if8.a = av[7:0]; if8.b = bv[7:0]; if8.signed_mode = sm;
        end
    endtask

    function automatic logic busy_of(input int w);
        return (w == 4) ? if4.busy : if8.busy;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 4) ? if4.done : if8.done;
    endfunction

    function automatic logic [63:0] prod_of(input int w);
        return (w == 4) ? 64'({if4.prod_hi, if4.prod_lo}) : 64'({if8.prod_hi, if8.prod_lo});
    endfunction

    // One full transaction: start pulse, scramble operands after capture, wait for done.
    task automatic op(input int w, input logic [31:0] av, input logic [31:0] bv,
                      input bit sm, input logic [63:0] expv, input string tag);
        int          lat;
        bit          got;
        logic [63:0] e;
        drive(w, 1'b1, av, bv, sm);
        exp_q.push_back(expv);
        @(negedge clk);
        drive(w, 1'b0, ~av, ~bv, ~sm);
        chk({tag, "_busy_start"}, 64'(busy_of(w)), 64'd1);
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            lat = i;
            if (done_of(w)) got = 1'b1;
        end
        e = exp_q.pop_front();
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, "_latency"}, 64'(lat), 64'(w + 1));
            chk({tag, "_product"}, prod_of(w), e);
        end
        @(negedge clk);
        chk({tag, "_done_end"}, 64'(done_of(w)), 64'd0);
        chk({tag, "_busy_end"}, 64'(busy_of(w)), 64'd0);
    endtask

    initial begin
        int          busy_cnt;
        int          d0;
        bit          got;
        logic [63:0] e;

        drive(4, 1'b0, 0, 0, 1'b0);
        drive(8, 1'b0, 0, 0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy4", 64'(if4.busy), 64'd0);
        chk("rst_done4", 64'(if4.done), 64'd0);
        chk("rst_prod4", prod_of(4), 64'd0);
        chk("rst_prod8", prod_of(8), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned directed cases
        op(4, 15, 15, 1'b0, 64'hE1, "u_15x15");
        op(4, 3, 7, 1'b0, 64'h15, "u_3x7");
        op(4, 0, 9, 1'b0, 64'h00, "u_0x9");
        op(4, 8, 2, 1'b0, 64'h10, "u_8x2");

        // Signed directed cases
        op(4, 4'h8, 4'h7, 1'b1, 64'hC8, "s_m8x7");
        op(4, 4'hF, 4'hF, 1'b1, 64'h01, "s_m1xm1");
        op(4, 4'h8, 4'h8, 1'b1, 64'h40, "s_m8xm8");

        // Start re-pulsed during CALC and again in the done cycle
        d0 = done_cnt4;
        drive(4, 1'b1, 3, 7, 1'b0);
        exp_q.push_back(64'h15);
        @(negedge clk);
        drive(4, 1'b1, 5, 5, 1'b0);
        busy_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (if4.busy) busy_cnt++;
            if (if4.done) begin
                got = 1'b1;
                e = exp_q.pop_front();
                chk("rep_product", prod_of(4), e);
                drive(4, 1'b1, 9, 9, 1'b0);
            end else if (i >= 2) begin
                drive(4, 1'b0, 5, 5, 1'b0);
            end
            @(negedge clk);
        end
        drive(4, 1'b0, 0, 0, 1'b0);
        chk("rep_done_seen", 64'(got), 64'd1);
        chk("rep_busy_cycles", 64'(busy_cnt), 64'd6);
        chk("rep_busy_after", 64'(if4.busy), 64'd0);
        repeat (8) @(negedge clk);
        chk("rep_one_done", 64'(done_cnt4 - d0), 64'd1);
        chk("rep_prod_held", prod_of(4), 64'h15);

        // Reset in the middle of CALC
        drive(4, 1'b1, 3, 3, 1'b0);
        @(negedge clk);
        drive(4, 1'b0, 3, 3, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 64'(if4.busy), 64'd0);
        chk("mid_rst_done", 64'(if4.done), 64'd0);
        chk("mid_rst_prod", prod_of(4), 64'd0);
        d0 = done_cnt4;
        repeat (8) @(negedge clk);
        chk("mid_rst_no_done", 64'(done_cnt4 - d0), 64'd0);
        op(4, 5, 9, 1'b0, 64'h2D, "post_rst_5x9");

        // WIDTH=8: corner case and sweep against the reference model
        op(8, 255, 255, 1'b0, 64'hFE01, "u8_255x255");
        for (int i = 0; i < 256; i++) begin
            op(8, 32'(i), 5, 1'b0, ref_mul(32'(i), 5, 1'b0, 8), "u8_sweep");
        end
        for (int i = 0; i < 256; i++) begin
            op(8, 32'(i), 5, 1'b1, ref_mul(32'(i), 5, 1'b1, 8), "s8_sweep");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_seq.md
# mult_seq

Parametrised sequential multiplier: the clocked successor to the 4-bit combinational multiplier. It computes a WIDTH×WIDTH product by radix-2 shift-add over WIDTH cycles, supports signed (two's-complement) and unsigned modes, and returns the 2·WIDTH-bit result split into low and high halves. It sits beside the ALU datapath and is driven through a start/busy/done handshake.

## Interface
- WIDTH, 4, operand width in bits; legal range 2–32; the product is 2·WIDTH bits.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = operands are two's-complement, 0 = unsigned; captured with start.
- a  in  WIDTH  multiplicand; captured with start.
- b  in  WIDTH  multiplier; captured with start.
- busy  out  1  high from the cycle after an accepted start until done deasserts.
- done  out  1  single-cycle pulse; result valid.
- prod_lo  out  WIDTH  product bits [WIDTH-1:0].
- prod_hi  out  WIDTH  product bits [2·WIDTH-1:WIDTH].

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: busy=0. start=1 at an edge captures a, b, signed_mode and moves to CALC.
  - Signed mode: operand magnitudes are loaded as |a|, |b| (WIDTH-bit unsigned; the most negative value's magnitude 2^(WIDTH-1) fits). neg_flag = a[MSB] XOR b[MSB].
  - Unsigned mode: operands are loaded as is; neg_flag = 0.
  - Accumulator (2·WIDTH bits) is cleared and the iteration counter is set to WIDTH.
- CALC: one multiplier bit per cycle, LSB first.
  - If the current multiplier bit is 1, add the multiplicand, shifted by the iteration index, into the accumulator.
  - The counter decrements each cycle. After exactly WIDTH cycles the state goes to FIX.
- FIX: one cycle. If neg_flag is set, the accumulator is negated (two's complement, 2·WIDTH bits). The state goes to DONE.
- DONE: one cycle. prod_lo/prod_hi are loaded at the edge entering DONE. done=1 for this cycle only. The next state is IDLE.
- Result rules:
  - prod_lo/prod_hi hold their value until the next result is loaded or reset.
  - No overflow is possible; there is no truncation.
- start while busy (CALC/FIX/DONE): ignored, with no effect on the operation in flight.
- start=1 in the cycle done=1: ignored. Because DONE → IDLE, the earliest back-to-back start is sampled in the following IDLE cycle.
- Operand changes after capture have no effect on the result.
- Reset (any state, including mid-operation):
  - Next edge: state=IDLE, busy=0, done=0, prod_lo=0, prod_hi=0, accumulator and counter cleared.
  - The operation in flight is discarded and no done pulse is produced.

## Timing
- Edge E0: start accepted. busy=1 from E0 through the end of the DONE cycle.
- Edges E1…E_WIDTH: CALC iterations.
- Edge E_WIDTH+1: FIX completes and the state enters DONE; prod_* updates and done=1.
- Edge E_WIDTH+2: done=0, busy=0, the block is in IDLE and can accept start.
- Latency from start-edge to done-high: WIDTH+1 edges. Throughput: one product per WIDTH+3 cycles.
- Reset values: busy=0, done=0, prod_lo=0, prod_hi=0.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Package mult_pkg holds:
  - the state enum (IDLE, CALC, FIX, DONE) and its width constant;
  - functions abs_w (WIDTH-bit magnitude) and neg_2w (2·WIDTH-bit two's-complement negate).
- Single module mult_seq with no sub-module. The datapath (accumulator, shifted multiplicand, counter) and the FSM are small enough to stay in one file.
- The counter width is $clog2(WIDTH+1).

## Test plan
- WIDTH=4, unsigned, a=15, b=15, start pulse → after WIDTH+1 edges done=1 with prod_hi=0xE, prod_lo=0x1; busy falls one cycle later.
- WIDTH=4, unsigned, a=3, b=7 → prod_hi=0x1, prod_lo=0x5. Then a=0, b=9 → prod_hi=0x0, prod_lo=0x0. Then a=8, b=2 → prod_hi=0x1, prod_lo=0x0.
- WIDTH=4, signed:
  - a=0x8 (−8), b=0x7 → prod_hi=0xC, prod_lo=0x8.
  - a=0xF, b=0xF (−1·−1) → 0x0/0x1.
  - a=0x8, b=0x8 (−8·−8) → 0x4/0x0.
- WIDTH=4, start re-pulsed with new operands during CALC and again in the done cycle → only the first result appears; exactly one done pulse; busy stays high for exactly WIDTH+2 cycles.
- WIDTH=4, rst=1 for one cycle during CALC → next cycle busy=0, done=0, prod=0; no done pulse follows. A new start then completes normally (5·9 → 0x2/0xD).
- WIDTH=8, sweep a=0..255 with b=5, unsigned and signed → every result matches the reference model. Corner case: unsigned 255·255 → prod_hi=0xFE, prod_lo=0x01.
